// File: rtl/phase_gen_pkg.sv
// Shared types and step-pattern constants for the three-phase test generator.
// Patterns are indexed by segment number 0..5, one bit per 60 degree segment.
package phase_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [2:0] STEP_LAST = 3'd5;

    localparam logic [5:0] PAT_R = 6'b000111;
    localparam logic [5:0] PAT_Y = 6'b011100;
    localparam logic [5:0] PAT_B = 6'b110001;

    // Returns {B, Y, R}; reverse rotation swaps the Y and B sequences.
    function automatic logic [2:0] phase_pattern(input logic [2:0] step, input logic rev);
        logic r;
        logic y;
        logic b;
        r = PAT_R[step];
        y = PAT_Y[step];
        b = PAT_B[step];
        return rev ? {y, b, r} : {b, y, r};
    endfunction

endpackage

// File: rtl/phase_gen_if.sv
// Control and phase-output bundle between the test sequencer and phase_gen.
// master drives the controls and observes the phases; slave is the generator.
interface phase_gen_if #(
    parameter int SEG_W = 16
);
    logic             enable;
    logic             start;
    logic             stop;
    logic             rev;
    logic [2:0]       drop;
    logic [SEG_W-1:0] seg_len;
    logic             chatter;

    logic             rphase;
    logic             yphase;
    logic             bphase;
    logic             running;
    logic [2:0]       step;
    logic             cycle_done;

    modport master (
        output enable, start, stop, rev, drop, seg_len, chatter,
        input  rphase, yphase, bphase, running, step, cycle_done
    );

    modport slave (
        input  enable, start, stop, rev, drop, seg_len, chatter,
        output rphase, yphase, bphase, running, step, cycle_done
    );
endinterface

// File: rtl/phase_gen_seg_timer.sv
// seg_timer: loadable down-counter that flags expiry when it sits at zero.
// Load wins over decrement; the counter parks at zero rather than wrapping.
module seg_timer #(
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [SEG_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    logic [SEG_W-1:0] cnt_q;
    logic [SEG_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - SEG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/phase_gen.sv
// phase_gen: six-segment R/Y/B square-wave generator for phase-monitor self-test.
// Optional contact-bounce injection is built when PHASEGEN_CHATTER_EN is defined.
module phase_gen
    import phase_gen_pkg::*;
#(
    parameter int SEG_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    phase_gen_if.slave bus
);

    state_e           state_q, state_d;
    logic [2:0]       step_q, step_d;
    logic [SEG_W-1:0] seg_l_q, seg_l_d;
    logic             rev_l_q, rev_l_d;
    logic [2:0]       drop_l_q, drop_l_d;
    logic [2:0]       phase_q, phase_d;
    logic             cyc_done_q, cyc_done_d;

    logic             tmr_load;
    logic             tmr_clear;
    logic [SEG_W-1:0] tmr_val;
    logic             tmr_expire;
    logic             tick_adv;

    // A zero segment length behaves as one tick per segment.
    function automatic logic [SEG_W-1:0] reload_val(input logic [SEG_W-1:0] len);
        return (len == '0) ? '0 : len - SEG_W'(1);
    endfunction

    seg_timer #(
        .SEG_W (SEG_W)
    ) u_seg_timer (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      ((state_q != IDLE) && bus.enable),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        seg_l_d    = seg_l_q;
        rev_l_d    = rev_l_q;
        drop_l_d   = drop_l_q;
        cyc_done_d = 1'b0;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_val    = reload_val(seg_l_q);
        tick_adv   = (state_q != IDLE) && bus.enable && tmr_expire;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d  = RUN;
                    step_d   = '0;
                    seg_l_d  = bus.seg_len;
                    rev_l_d  = bus.rev;
                    drop_l_d = bus.drop;
                    tmr_load = 1'b1;
                    tmr_val  = reload_val(bus.seg_len);
                end
            end
            RUN, DRAIN: begin
                if ((state_q == RUN) && bus.stop) begin
                    state_d = DRAIN;
                end
                if (tick_adv) begin
                    tmr_load = 1'b1;
                    if (step_q == STEP_LAST) begin
                        step_d     = '0;
                        cyc_done_d = 1'b1;
                        // A stop landing on the final tick still ends this cycle.
                        if ((state_q == DRAIN) || bus.stop) begin
                            state_d   = IDLE;
                            tmr_load  = 1'b0;
                            tmr_clear = 1'b1;
                        end else begin
                            seg_l_d  = bus.seg_len;
                            rev_l_d  = bus.rev;
                            drop_l_d = bus.drop;
                            tmr_val  = reload_val(bus.seg_len);
                        end
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase

        phase_d = (state_d == IDLE) ? 3'b000 : (phase_pattern(step_d, rev_l_d) & ~drop_l_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            seg_l_q    <= '0;
            rev_l_q    <= 1'b0;
            drop_l_q   <= '0;
            phase_q    <= '0;
            cyc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            seg_l_q    <= seg_l_d;
            rev_l_q    <= rev_l_d;
            drop_l_q   <= drop_l_d;
            phase_q    <= phase_d;
            cyc_done_q <= cyc_done_d;
        end
    end

`ifdef PHASEGEN_CHATTER_EN
    // Each clean edge taken with chatter set inverts that phase until the next enable tick.
    logic [2:0] glitch_q, glitch_d;

    always_comb begin
        glitch_d = glitch_q;
        if (bus.enable) begin
            glitch_d = 3'b000;
        end
        if (state_d == IDLE) begin
            glitch_d = 3'b000;
        end else if (bus.chatter) begin
            glitch_d = glitch_d | ((phase_d ^ phase_q) & ~drop_l_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign bus.rphase = phase_q[0] ^ glitch_q[0];
    assign bus.yphase = phase_q[1] ^ glitch_q[1];
    assign bus.bphase = phase_q[2] ^ glitch_q[2];
`else
    assign bus.rphase = phase_q[0];
    assign bus.yphase = phase_q[1];
    assign bus.bphase = phase_q[2];
`endif

    assign bus.running    = (state_q != IDLE);
    assign bus.step       = step_q;
    assign bus.cycle_done = cyc_done_q;

endmodule

// File: tb/tb_phase_gen.sv
// Randomized self-checking bench for phase_gen against a tick-count reference model.
// Targets the default build (PHASEGEN_CHATTER_EN undefined: chatter must have no effect).
module tb_phase_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    phase_gen_if #(.SEG_W(16)) bus ();

    phase_gen #(.SEG_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: position within the 360 degree cycle counted in enable ticks.
    bit         m_run;
    bit         m_pend;
    bit         m_cd;
    bit         m_rev;
    int         m_t;
    int         m_L;
    logic [2:0] m_drop;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_cd = 0; m_rev = 0;
        m_t = 0; m_L = 1; m_drop = 3'b000;
    endtask

    task automatic model_latch();
        m_L    = (bus.seg_len == 0) ? 1 : int'(bus.seg_len);
        m_rev  = bus.rev;
        m_drop = bus.drop;
    endtask

    task automatic model_step();
        m_cd = 0;
        if (!m_run) begin
            if (bus.start && !bus.stop) begin
                m_run = 1; m_pend = 0; m_t = 0;
                model_latch();
            end
        end else begin
            if (bus.stop) m_pend = 1;
            if (bus.enable) begin
                m_t++;
                if (m_t == 6 * m_L) begin
                    m_cd = 1;
                    m_t  = 0;
                    if (m_pend) begin
                        m_run = 0; m_pend = 0;
                    end else begin
                        model_latch();
                    end
                end
            end
        end
    endtask

    function automatic int exp_step();
        return m_run ? (m_t / m_L) : 0;
    endfunction

    // {B, Y, R}: R leads, the lagging phases are 120 and 240 degrees behind.
    function automatic logic [2:0] exp_pat();
        int s;
        logic r, yf, bf, y, b;
        if (!m_run) return 3'b000;
        s  = m_t / m_L;
        r  = (s < 3);
        yf = (s >= 2) && (s <= 4);
        bf = (s >= 4) || (s == 0);
        y  = m_rev ? bf : yf;
        b  = m_rev ? yf : bf;
        return {b, y, r} & ~m_drop;
    endfunction

    task automatic compare();
        logic [2:0] e;
        e = exp_pat();
        chk("rphase", 16'(bus.rphase), 16'(e[0]));
        chk("yphase", 16'(bus.yphase), 16'(e[1]));
        chk("bphase", 16'(bus.bphase), 16'(e[2]));
        chk("running", 16'(bus.running), 16'(m_run));
        chk("step", 16'(bus.step), 16'(exp_step()));
        chk("cycle_done", 16'(bus.cycle_done), 16'(m_cd));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_r"}, 16'(bus.rphase), 16'd0);
        chk({tag, "_y"}, 16'(bus.yphase), 16'd0);
        chk({tag, "_b"}, 16'(bus.bphase), 16'd0);
        chk({tag, "_running"}, 16'(bus.running), 16'd0);
        chk({tag, "_step"}, 16'(bus.step), 16'd0);
    endtask

    // Called at a negedge; asserts rst between clock edges.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare();
        rst = 1'b0;
    endtask

    initial begin
        int cnt_r, cnt_y, cnt_b, cnt_cd;
        bit got;

        bus.enable = 0; bus.start = 0; bus.stop = 0; bus.rev = 0;
        bus.drop = 3'b000; bus.seg_len = '0; bus.chatter = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_cd", 16'(bus.cycle_done), 16'd0);
        rst = 1'b0;
        cyc();

        // Forward rotation, seg_len 4, free-running enable.
        bus.seg_len = 16'd4; bus.rev = 0; bus.drop = 3'b000; bus.enable = 1; bus.start = 1;
        cyc();
        bus.start = 0;
        chk("start_r", 16'(bus.rphase), 16'd1);
        chk("start_y", 16'(bus.yphase), 16'd0);
        chk("start_b", 16'(bus.bphase), 16'd1);
        chk("start_running", 16'(bus.running), 16'd1);
        chk("start_step", 16'(bus.step), 16'd0);
        cnt_r = int'(bus.rphase);
        for (int k = 1; k <= 30; k++) begin
            bus.chatter = 1'($urandom);
            cyc();
            if (k < 24) cnt_r += int'(bus.rphase);
            if (k == 4)  chk("fwd_step_k4", 16'(bus.step), 16'd1);
            if (k == 7)  chk("fwd_y_k7", 16'(bus.yphase), 16'd0);
            if (k == 8)  chk("fwd_y_k8", 16'(bus.yphase), 16'd1);
            if (k == 23) chk("fwd_cd_k23", 16'(bus.cycle_done), 16'd0);
            if (k == 24) chk("fwd_cd_k24", 16'(bus.cycle_done), 16'd1);
        end
        chk("fwd_r_high_count", 16'(cnt_r), 16'd12);

        // Reverse rotation, seg_len 2, requested mid-cycle.
        bus.rev = 1; bus.seg_len = 16'd2;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            cyc();
            if (bus.cycle_done) got = 1;
        end
        chk("rev_wait_cd", 16'(got), 16'd1);
        chk("rev_k0_r", 16'(bus.rphase), 16'd1);
        chk("rev_k0_b", 16'(bus.bphase), 16'd0);
        repeat (3) cyc();
        chk("rev_b_k3", 16'(bus.bphase), 16'd0);
        cyc();
        chk("rev_b_k4", 16'(bus.bphase), 16'd1);
        repeat (3) cyc();
        chk("rev_y_k7", 16'(bus.yphase), 16'd0);
        cyc();
        chk("rev_y_k8", 16'(bus.yphase), 16'd1);

        // Y dropout requested mid-cycle; applies from the next boundary.
        bus.drop = 3'b010;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            cyc();
            if (bus.cycle_done) got = 1;
        end
        chk("drop_wait_cd", 16'(got), 16'd1);
        cnt_r = int'(bus.rphase); cnt_y = int'(bus.yphase); cnt_b = int'(bus.bphase);
        repeat (11) begin
            cyc();
            cnt_r += int'(bus.rphase); cnt_y += int'(bus.yphase); cnt_b += int'(bus.bphase);
        end
        chk("drop_y_count", 16'(cnt_y), 16'd0);
        chk("drop_r_count", 16'(cnt_r), 16'd6);
        chk("drop_b_count", 16'(cnt_b), 16'd6);

        // Stop in step 1 drains to the end of the cycle.
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (m_run && (m_t / m_L) == 1) got = 1;
            else cyc();
        end
        chk("stop_find_step1", 16'(got), 16'd1);
        bus.stop = 1;
        cyc();
        bus.stop = 0;
        cnt_cd = 0;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            cyc();
            cnt_cd += int'(bus.cycle_done);
            if (!bus.running) got = 1;
        end
        chk("stop_reached_idle", 16'(got), 16'd1);
        chk("stop_cd_count", 16'(cnt_cd), 16'd1);
        cyc();
        chk_all_zero("stop_idle");

        // seg_len 0 with enable toggling; reset asynchronously mid step 3.
        bus.seg_len = 16'd0; bus.rev = 0; bus.drop = 3'b000; bus.enable = 0; bus.start = 1;
        cyc();
        bus.start = 0;
        chk("len0_step_k0", 16'(bus.step), 16'd0);
        for (int k = 1; k <= 6; k++) begin
            bus.enable = (k % 2 == 1);
            cyc();
            if (k == 2) chk("len0_step_k2", 16'(bus.step), 16'd1);
            if (k == 4) chk("len0_step_k4", 16'(bus.step), 16'd2);
            if (k == 6) chk("len0_step_k6", 16'(bus.step), 16'd3);
            if (k == 6) chk("len0_y_k6", 16'(bus.yphase), 16'd1);
        end
        do_reset();

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.enable  = ($urandom % 4) != 0;
            bus.start   = ($urandom % 8) == 0;
            bus.stop    = ($urandom % 40) == 0;
            bus.rev     = 1'($urandom);
            bus.drop    = 3'($urandom);
            bus.seg_len = 16'($urandom_range(0, 4));
            bus.chatter = 1'($urandom);
            if (($urandom % 500) == 0) do_reset();
            else cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/phase_gen.md
# phase_gen

Three-phase square-wave generator producing R/Y/B phase-indication levels for bench self-test of the phase-monitor path. It steps a six-segment (60° per segment) sequence timed by enable ticks, with selectable rotation and per-phase dropout injection. It sits beside the phase monitor in the PC2118 FPGA and drives its phase inputs through a test mux.

## Interface
- SEG_W, 16: width of segment-length input and segment counter.
- clk  in  1  system clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  tick qualifier; counters advance only on clk edges with enable=1.
- start  in  1  level/pulse; begins generation from IDLE.
- stop  in  1  pulse; requests halt at the next cycle boundary.
- rev  in  1  0 = R-Y-B rotation, 1 = R-B-Y rotation.
- drop  in  3  forced-missing mask {B,Y,R}; bit set holds that phase low.
- seg_len  in  SEG_W  enable ticks per 60° segment; 0 is treated as 1.
- chatter  in  1  glitch-injection request (used only with PHASEGEN_CHATTER_EN).
- rphase, yphase, bphase  out  1 each  generated phase levels, registered.
- running  out  1  high in RUN and DRAIN.
- step  out  3  current segment 0..5, 0 in IDLE.
- cycle_done  out  1  one-clk pulse at each completed 360° cycle.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: all outputs 0. start=1 with stop=0 -> RUN. start and stop both high -> stays IDLE.
- RUN: step advances when the segment counter expires; 5 wraps to 0.
- stop in RUN -> DRAIN. start in RUN/DRAIN ignored.
- DRAIN: same as RUN. At the end of step 5 -> IDLE.
- Forward pattern (rev=0): R high in steps 0,1,2; Y high in steps 2,3,4; B high in steps 4,5,0.
- Reverse pattern (rev=1): Y and B patterns swapped.
- Masking: output = pattern & ~drop_l, where drop_l is the latched drop mask.
- Latching: seg_len, rev and drop are captured into seg_l/rev_l/drop_l on IDLE->RUN and at every cycle boundary. Changes mid-cycle take effect only on the next cycle.
- Segment counter: loaded with max(seg_l,1)-1. It decrements on enable. At 0 with enable, the step advances and the counter reloads.
- cycle_done: pulses on the clk edge that leaves step 5, including the final cycle in DRAIN.

## Timing
- Reset values: all outputs 0; state IDLE; counters and latches 0. Reset takes effect immediately, including mid-cycle.
- Start latency: on the clk edge sampling start=1 in IDLE (enable not required), the block enters RUN and outputs show step 0 (R=1, Y=0, B=1 forward) on that edge.
- Each step lasts exactly seg_l enable ticks. A full cycle lasts 6·seg_l ticks.
- stop is registered as pending in the cycle it arrives. A stop during step 5's last tick still completes the current cycle only.
- enable=0 freezes counter and step. Outputs hold.

## Configuration
- PHASEGEN_CHATTER_EN defined: on each edge of a generated phase, if chatter=1 at that edge, the phase inverts for the next one enable tick, then resumes. This models contact bounce. Masked phases never chatter.
- Undefined: the chatter input is ignored and outputs are clean.

## Structure
- Package phase_gen_pkg: state enum {IDLE, RUN, DRAIN}; STEP_LAST=5; forward R/Y/B step-pattern constants (6-bit masks 6'b000111, 6'b011100, 6'b110001).
- One sub-module, seg_timer: loadable down-counter with expire flag, SEG_W wide.

## Test plan
- Reset, then start with seg_len=4, rev=0, drop=0, enable=1 constant. Expect R/Y/B follow steps 0..5, each 4 clks, with R high 12 of every 24 clks. Y rises 8 clks after R. cycle_done pulses every 24 clks.
- rev=1, seg_len=2. Expect B rises 4 clks after R, and Y rises 8 clks after R.
- drop=3'b010 set mid-cycle. Expect Y still toggling until the next cycle_done, then Y held low; R and B unchanged.
- stop pulsed in step 1. Expect the cycle to run through step 5, one cycle_done, then IDLE with all outputs 0 and running=0.
- seg_len=0 with enable toggling every other clk. Expect each step to last 1 enable tick (2 clks). Assert rst mid-step 3 and expect all outputs 0 asynchronously.
- With PHASEGEN_CHATTER_EN defined, chatter=1 and seg_len=5. Expect a 1-tick inverted glitch after every R/Y/B edge. With the macro undefined, expect no glitches.
